// File: rtl/mem_tg_chan_seq.sv
// ---------------------------------------------------------------------------
// mem_tg_chan_seq
//
// Per-channel run sequencer between the memory traffic-generator CSR block
// and the per-channel traffic generators. A write to MEM_TG_CTRL launches
// every channel whose tg_init_n bit is written as 0. Each channel then runs
// its own IDLE -> START -> RUN -> DONE sequence. It issues a single start
// pulse, guards the run with a watchdog timeout, and keeps its results
// sticky until the next launch.
//
// Optional feature (macro MEM_TG_PERF_CNT_EN):
//   defined   - tg_elapsed[i] captures the RUN cycle count when channel i
//               finishes (by complete or timeout), cleared on launch.
//   undefined - tg_elapsed is tied to 0 and no elapsed registers exist.
//
// Ports:
//   clk           clock
//   rst           asynchronous reset, active-high
//   csr_ctrl_wr   one-cycle pulse when MEM_TG_CTRL is written
//   csr_ctrl_data write data, bit i = tg_init_n for channel i
//   tg_start      one-cycle start pulse per launched channel
//   tg_complete   TG i test complete, only looked at while in RUN
//   tg_pass_in    TG i pass, qualified by tg_complete[i]
//   tg_fail_in    TG i fail, qualified by tg_complete[i]
//   tg_stat       channel i at [4i+3:4i] = {pass, fail, timeout, active}
//   busy          OR of all active bits
//   tg_elapsed    per-channel run length, TO_CNT_W bits per channel
// ---------------------------------------------------------------------------
module mem_tg_chan_seq #(
    parameter int          NUM_CH         = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          TO_CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         csr_ctrl_wr,
    input  logic [NUM_CH-1:0]            csr_ctrl_data,
    output logic [NUM_CH-1:0]            tg_start,
    input  logic [NUM_CH-1:0]            tg_complete,
    input  logic [NUM_CH-1:0]            tg_pass_in,
    input  logic [NUM_CH-1:0]            tg_fail_in,
    output logic [4*NUM_CH-1:0]          tg_stat,
    output logic                         busy,
    output logic [TO_CNT_W*NUM_CH-1:0]   tg_elapsed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ch_state_e;

    // Counter value seen in the last RUN cycle before a timeout fires.
    localparam logic [TO_CNT_W-1:0] TO_LAST  = TO_CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic                TO_EN    = (TIMEOUT_CYCLES != 32'd0);

    logic [NUM_CH-1:0] active_vec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_e             state;
        ch_state_e             state_next;
        logic [TO_CNT_W-1:0]   cnt;
        logic [TO_CNT_W-1:0]   cnt_sat;
        logic                  pass_q;
        logic                  fail_q;
        logic                  to_q;
        logic                  launch;
        logic                  hit_to;
        logic                  start_o;
        logic                  active_o;

        assign launch  = csr_ctrl_wr & ~csr_ctrl_data[i];
        assign hit_to  = TO_EN && (cnt == TO_LAST);
        // The count sticks at all-ones rather than wrapping.
        assign cnt_sat = (&cnt) ? cnt : cnt + TO_CNT_W'(1);

        // State register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
            end else begin
                state <= state_next;
            end
        end

        // Next-state logic; launches in START or RUN are deliberately ignored
        always_comb begin
            state_next = state;
            case (state)
                IDLE, DONE: if (launch) state_next = START;
                START:      state_next = RUN;
                RUN:        if (tg_complete[i] || hit_to) state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end

        // Run counter and sticky result bits. When complete and timeout
        // coincide, complete takes priority and timeout stays clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
                to_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (launch) begin
                            cnt    <= '0;
                            pass_q <= 1'b0;
                            fail_q <= 1'b0;
                            to_q   <= 1'b0;
                        end
                    end
                    RUN: begin
                        cnt <= cnt_sat;
                        if (tg_complete[i]) begin
                            pass_q <= tg_pass_in[i] & ~tg_fail_in[i];
                            fail_q <= tg_fail_in[i];
                            to_q   <= 1'b0;
                        end else if (hit_to) begin
                            to_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Output decode straight from the state flops
        always_comb begin
            start_o  = (state == START);
            active_o = (state == START) || (state == RUN);
        end

        assign tg_start[i]        = start_o;
        assign active_vec[i]      = active_o;
        assign tg_stat[4*i +: 4]  = {pass_q, fail_q, to_q, active_o};

`ifdef MEM_TG_PERF_CNT_EN
        logic [TO_CNT_W-1:0] elapsed_q;

        // Capture the RUN length on the way into DONE, clear on relaunch
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                elapsed_q <= '0;
            end else if ((state == IDLE || state == DONE) && launch) begin
                elapsed_q <= '0;
            end else if (state == RUN && (tg_complete[i] || hit_to)) begin
                elapsed_q <= cnt_sat;
            end
        end

        assign tg_elapsed[TO_CNT_W*i +: TO_CNT_W] = elapsed_q;
`endif
    end

`ifndef MEM_TG_PERF_CNT_EN
    assign tg_elapsed = '0;
`endif

    assign busy = |active_vec;

endmodule

// File: tb/tb_mem_tg_chan_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_tg_chan_seq
//
// Directed self-checking bench for mem_tg_chan_seq with TIMEOUT_CYCLES=16.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, away from the active edge. Elapsed-count expectations
// follow MEM_TG_PERF_CNT_EN (zero when the feature is compiled out).
// ---------------------------------------------------------------------------
module tb_mem_tg_chan_seq;

    localparam int NUM_CH = 4;
    localparam int TO_W   = 32;

    logic                     clk;
    logic                     rst;
    logic                     csr_ctrl_wr;
    logic [NUM_CH-1:0]        csr_ctrl_data;
    logic [NUM_CH-1:0]        tg_start;
    logic [NUM_CH-1:0]        tg_complete;
    logic [NUM_CH-1:0]        tg_pass_in;
    logic [NUM_CH-1:0]        tg_fail_in;
    logic [4*NUM_CH-1:0]      tg_stat;
    logic                     busy;
    logic [TO_W*NUM_CH-1:0]   tg_elapsed;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MEM_TG_PERF_CNT_EN
    localparam logic [31:0] EL10 = 32'd10;
    localparam logic [31:0] EL16 = 32'd16;
`else
    localparam logic [31:0] EL10 = 32'd0;
    localparam logic [31:0] EL16 = 32'd0;
`endif

    mem_tg_chan_seq #(
        .NUM_CH         (NUM_CH),
        .TIMEOUT_CYCLES (32'd16),
        .TO_CNT_W       (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr_ctrl_wr   (csr_ctrl_wr),
        .csr_ctrl_data (csr_ctrl_data),
        .tg_start      (tg_start),
        .tg_complete   (tg_complete),
        .tg_pass_in    (tg_pass_in),
        .tg_fail_in    (tg_fail_in),
        .tg_stat       (tg_stat),
        .busy          (busy),
        .tg_elapsed    (tg_elapsed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle MEM_TG_CTRL write; returns just after the sampling edge
    task automatic apply_stimulus(input logic [NUM_CH-1:0] data);
        csr_ctrl_wr   = 1'b1;
        csr_ctrl_data = data;
        step(1);
        csr_ctrl_wr   = 1'b0;
        csr_ctrl_data = '1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        csr_ctrl_wr   = 1'b0;
        csr_ctrl_data = '1;
        tg_complete   = '0;
        tg_pass_in    = '0;
        tg_fail_in    = '0;
        step(3);
        rst = 1'b0;
        step(1);
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_start: got %b expected %b", tg_start, 4'b0000); end
        n_cmp++; if (tg_stat !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_stat: got %h expected %h", tg_stat, 16'h0000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (tg_elapsed !== '0) begin n_fail++; $display("[TB] FAIL reset_elapsed: got %h expected 0", tg_elapsed); end
    endtask

    // Channel 0: launch, single start pulse, pass after 10 RUN cycles
    task automatic test_launch_pass();
        apply_stimulus(4'b1110);
        n_cmp++; if (tg_start !== 4'b0001) begin n_fail++; $display("[TB] FAIL launch_start: got %b expected %b", tg_start, 4'b0001); end
        n_cmp++; if (tg_stat !== 16'h0001) begin n_fail++; $display("[TB] FAIL launch_stat: got %h expected %h", tg_stat, 16'h0001); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL launch_busy: got %b expected %b", busy, 1'b1); end
        step(1);
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL start_one_cycle: got %b expected %b", tg_start, 4'b0000); end
        n_cmp++; if (tg_stat !== 16'h0001) begin n_fail++; $display("[TB] FAIL run_stat: got %h expected %h", tg_stat, 16'h0001); end
        // now in RUN cycle 1; move to RUN cycle 10
        step(9);
        tg_complete[0] = 1'b1;
        tg_pass_in[0]  = 1'b1;
        step(1);
        tg_complete[0] = 1'b0;
        tg_pass_in[0]  = 1'b0;
        n_cmp++; if (tg_stat[3:0] !== 4'b1000) begin n_fail++; $display("[TB] FAIL pass_stat: got %b expected %b", tg_stat[3:0], 4'b1000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_busy: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (tg_elapsed[31:0] !== EL10) begin n_fail++; $display("[TB] FAIL pass_elapsed: got %0d expected %0d", tg_elapsed[31:0], EL10); end
        // DONE must ignore tg_complete
        tg_complete[0] = 1'b1;
        tg_fail_in[0]  = 1'b1;
        step(2);
        tg_complete[0] = 1'b0;
        tg_fail_in[0]  = 1'b0;
        n_cmp++; if (tg_stat !== 16'h0008) begin n_fail++; $display("[TB] FAIL done_sticky: got %h expected %h", tg_stat, 16'h0008); end
    endtask

    // Channel 2: no complete, timeout after 16 RUN cycles
    task automatic test_timeout();
        apply_stimulus(4'b1011);
        n_cmp++; if (tg_start !== 4'b0100) begin n_fail++; $display("[TB] FAIL to_start: got %b expected %b", tg_start, 4'b0100); end
        step(1);
        for (int k = 1; k < 16; k++) begin
            n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL to_no_restart: got %b expected %b at run %0d", tg_start, 4'b0000, k); end
            step(1);
        end
        n_cmp++; if (tg_stat[11:8] !== 4'b0001) begin n_fail++; $display("[TB] FAIL to_still_run: got %b expected %b", tg_stat[11:8], 4'b0001); end
        step(1);
        n_cmp++; if (tg_stat !== 16'h0208) begin n_fail++; $display("[TB] FAIL to_stat: got %h expected %h", tg_stat, 16'h0208); end
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL to_start_after: got %b expected %b", tg_start, 4'b0000); end
        n_cmp++; if (tg_elapsed[95:64] !== EL16) begin n_fail++; $display("[TB] FAIL to_elapsed: got %0d expected %0d", tg_elapsed[95:64], EL16); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL to_busy: got %b expected %b", busy, 1'b0); end
    endtask

    // Channel 1: complete with pass and fail in the timeout cycle
    task automatic test_complete_vs_timeout();
        apply_stimulus(4'b1101);
        step(1);
        step(15);
        tg_complete[1] = 1'b1;
        tg_pass_in[1]  = 1'b1;
        tg_fail_in[1]  = 1'b1;
        step(1);
        tg_complete[1] = 1'b0;
        tg_pass_in[1]  = 1'b0;
        tg_fail_in[1]  = 1'b0;
        n_cmp++; if (tg_stat[7:4] !== 4'b0100) begin n_fail++; $display("[TB] FAIL both_stat: got %b expected %b", tg_stat[7:4], 4'b0100); end
        n_cmp++; if (tg_stat !== 16'h0248) begin n_fail++; $display("[TB] FAIL both_isolation: got %h expected %h", tg_stat, 16'h0248); end
        n_cmp++; if (tg_elapsed[63:32] !== EL16) begin n_fail++; $display("[TB] FAIL both_elapsed: got %0d expected %0d", tg_elapsed[63:32], EL16); end
    endtask

    // Channel 3: relaunch in RUN is ignored, relaunch after DONE restarts
    task automatic test_relaunch();
        apply_stimulus(4'b0111);
        step(1);
        step(3);
        // RUN cycle 4: relaunch write lands here
        apply_stimulus(4'b0111);
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL relaunch_run_start: got %b expected %b", tg_start, 4'b0000); end
        n_cmp++; if (tg_stat[15:12] !== 4'b0001) begin n_fail++; $display("[TB] FAIL relaunch_run_stat: got %b expected %b", tg_stat[15:12], 4'b0001); end
        // RUN cycle 5 now; the counter kept going so timeout still hits at 16
        step(11);
        n_cmp++; if (tg_stat[15:12] !== 4'b0001) begin n_fail++; $display("[TB] FAIL relaunch_cnt_pre: got %b expected %b", tg_stat[15:12], 4'b0001); end
        step(1);
        n_cmp++; if (tg_stat !== 16'h2248) begin n_fail++; $display("[TB] FAIL relaunch_cnt_to: got %h expected %h", tg_stat, 16'h2248); end
        apply_stimulus(4'b0111);
        n_cmp++; if (tg_start !== 4'b1000) begin n_fail++; $display("[TB] FAIL relaunch_done_start: got %b expected %b", tg_start, 4'b1000); end
        n_cmp++; if (tg_stat !== 16'h1248) begin n_fail++; $display("[TB] FAIL relaunch_done_stat: got %h expected %h", tg_stat, 16'h1248); end
        n_cmp++; if (tg_elapsed[127:96] !== 32'd0) begin n_fail++; $display("[TB] FAIL relaunch_elapsed_clr: got %0d expected 0", tg_elapsed[127:96]); end
        step(1);
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL relaunch_single_pulse: got %b expected %b", tg_start, 4'b0000); end
    endtask

    // All channels launched, then reset mid-run
    task automatic test_reset_mid_run();
        step(20);
        apply_stimulus(4'b0000);
        n_cmp++; if (tg_start !== 4'b1111) begin n_fail++; $display("[TB] FAIL all_start: got %b expected %b", tg_start, 4'b1111); end
        n_cmp++; if (tg_stat !== 16'h1111) begin n_fail++; $display("[TB] FAIL all_stat: got %h expected %h", tg_stat, 16'h1111); end
        step(3);
        rst = 1'b1;
        #1;
        n_cmp++; if (tg_start !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_mid_start: got %b expected %b", tg_start, 4'b0000); end
        n_cmp++; if (tg_stat !== 16'h0000) begin n_fail++; $display("[TB] FAIL rst_mid_stat: got %h expected %h", tg_stat, 16'h0000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_busy: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (tg_elapsed !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_elapsed: got %h expected 0", tg_elapsed); end
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            n_cmp++; if (tg_start !== 4'b0000 || tg_stat !== 16'h0000) begin n_fail++; $display("[TB] FAIL post_rst_idle: got start=%b stat=%h expected start=0000 stat=0000", tg_start, tg_stat); end
        end
    endtask

    initial begin
        test_reset();
        test_launch_pass();
        test_timeout();
        test_complete_vs_timeout();
        test_relaunch();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
